ds2b_win_uni: RTL and testbench
===============================

# ds2b_win_uni

Deterministic unipolar stochastic-to-binary decoder for the scu library. Counts ones in a unipolar bitstream over a programmed window and returns the binary count with a one-cycle done pulse. It is the receiving end for the unipolar stream generators and rotation multipliers. Downstream logic reads the binary result instead of the raw stream.

## Interface
- INWD, 8, binary precision of the producing stream unit
- WINWD, 2*INWD, log2 of the maximum window length
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  start/restart pulse; samples iLen
- iLen  in  WINWD  window length in enabled bits; 0 encodes 2^WINWD
- iEn  in  1  qualifies iBit this cycle
- iBit  in  1  unipolar stream bit
- oC  out  WINWD+1  count of ones in the last completed window
- oDone  out  1  one-cycle pulse when oC updates
- oBusy  out  1  window in progress

## Operation
- States: IDLE, RUN.
- IDLE:
  - oBusy=0.
  - load=1 latches the remaining count rem as follows: iLen==0 gives 2^WINWD, else iLen.
  - load=1 also clears the ones accumulator acc and moves to RUN.
- RUN:
  - oBusy=1.
  - Each edge with iEn=1 does acc+=iBit and rem-=1.
  - iEn=0 cycles are ignored; state and counters hold.
- Completion: the edge that samples the final enabled bit (rem==1, iEn=1) does all of the following:
  - writes oC=acc+iBit.
  - raises oDone for exactly that following cycle.
  - returns to IDLE (see Configuration for continuous mode).
- oC holds its value until the next completion. oC is never cleared by load.
- load while in RUN aborts the current window:
  - counters reload from iLen.
  - no oDone is generated.
  - oC is unchanged.
- load coincident with the final bit: load wins. There is no oDone, oC is unchanged, and the new window starts.
- iBit on the load cycle is not counted.
- Arithmetic:
  - acc is WINWD+1 bits, so an all-ones 2^WINWD window yields oC=2^WINWD exactly. No saturation, no wrap.
  - rem is WINWD+1 bits.
- Reset mid-window: all state is dropped immediately.

## Timing
- Reset values: state=IDLE, oC=0, oDone=0, oBusy=0, acc=0, rem=0.
- All outputs are registered.
- With load at edge k and iEn held high, bits are sampled at edges k+1..k+N.
- oDone is high during the cycle after edge k+N.
- oBusy is high from after edge k through after edge k+N-1. It falls after edge k+N.
- oDone and oBusy are never both high in non-continuous mode.
- Latency from the final enabled bit to a valid oC is 1 cycle.

## Configuration
- DS2B_CONT_EN, when defined:
  - On completion, the block reloads rem from the last latched length, clears acc, and stays in RUN.
  - This gives back-to-back windows with no gap; oBusy stays 1 and oDone pulses once per window.
  - load still aborts and restarts with a new iLen.
- Not defined: the block returns to IDLE after each window and waits for load.

## Structure
- Package ds2b_pkg holds:
  - the state enum typedef (IDLE, RUN).
  - the default INWD/WINWD constants.
  - the length-decode helper: 0 maps to 2^WINWD.
- Sub-module ds2b_win_cnt is the loadable window down-counter. It takes load, the decoded length and iEn, and outputs rem and a last-bit flag.
- The top holds the FSM, acc and the output registers.

## Test plan
- Reset and idle:
  - Assert rst mid-run. Outputs must read oC=0, oDone=0, oBusy=0 asynchronously.
  - After release, the block idles with oBusy=0.
- Basic window: iLen=4, iEn=1, bits 1,0,1,1 → oC=3, one oDone pulse 4 cycles after load+1, then oBusy=0.
- Enable gaps: iLen=3, iEn pattern 1,0,1,0,1 with bits 1,1,0,1,1 → oC=2 (gated bits ignored), oDone after the 5th cycle.
- Full window: INWD=8, iLen=0, iBit=1 held for 65536 enabled cycles → oC=65536 (17 bits).
- Abort: iLen=8, load again after 3 bits with iLen=2, bits 1,1 → no oDone from the first window, then oC=2.
- Collision and continuous mode:
  - load on the final-bit cycle → no oDone, oC unchanged.
  - With DS2B_CONT_EN: iLen=2, alternating bits 1,0 → oDone every 2 cycles, each with oC=1, oBusy constantly 1.

Source files
------------

// File: rtl/ds2b_pkg.sv
// Shared types, default widths and the window-length decode for the ds2b decoders.
package ds2b_pkg;

  localparam int INWD_DEF  = 8;
  localparam int WINWD_DEF = 2 * INWD_DEF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A programmed length of zero stands for the full 2^w window.
  function automatic logic [32:0] len_decode(input logic [31:0] len, input int unsigned w);
    if (len == 32'd0) begin
      len_decode = 33'd1 << w;
    end else begin
      len_decode = {1'b0, len};
    end
  endfunction

endpackage

// File: rtl/ds2b_win_cnt.sv
// Loadable window down-counter: tracks the enabled bits left in the current window.
module ds2b_win_cnt
  import ds2b_pkg::*;
#(
  parameter int WINWD = WINWD_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [WINWD:0] len,
  input  logic           en,
  input  logic           run,
  input  logic           wrap,
  output logic [WINWD:0] rem,
  output logic           last
);

  logic [WINWD:0] rem_q, rem_d;
  logic [WINWD:0] len_q, len_d;

  assign rem  = rem_q;
  assign last = (rem_q == {{WINWD{1'b0}}, 1'b1});

  // Load takes priority; wrap reloads the latched length for back-to-back windows.
  always_comb begin
    rem_d = rem_q;
    len_d = len_q;
    if (load) begin
      rem_d = len;
      len_d = len;
    end else if (run && en) begin
      if (last && wrap) begin
        rem_d = len_q;
      end else begin
        rem_d = rem_q - {{WINWD{1'b0}}, 1'b1};
      end
    end else begin
      rem_d = rem_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= {(WINWD+1){1'b0}};
      len_q <= {(WINWD+1){1'b0}};
    end else begin
      rem_q <= rem_d;
      len_q <= len_d;
    end
  end

endmodule

// File: rtl/ds2b_win_uni.sv
// Unipolar stochastic-to-binary decoder: counts ones over a programmed window.
// Define DS2B_CONT_EN for continuous back-to-back windows after the first load.
module ds2b_win_uni
  import ds2b_pkg::*;
#(
  parameter int INWD  = INWD_DEF,
  parameter int WINWD = 2 * INWD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WINWD-1:0] iLen,
  input  logic             iEn,
  input  logic             iBit,
  output logic [WINWD:0]   oC,
  output logic             oDone,
  output logic             oBusy
);

`ifdef DS2B_CONT_EN
  localparam logic CONT = 1'b1;
`else
  localparam logic CONT = 1'b0;
`endif

  state_e         state_q, state_d;
  logic [WINWD:0] acc_q, acc_d;
  logic [WINWD:0] oc_q, oc_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic [WINWD:0] dec_len_s;
  logic [WINWD:0] rem_s;
  logic           last_s;
  logic [WINWD:0] sum_s;

  assign dec_len_s = (WINWD+1)'(len_decode(32'(iLen), WINWD));
  assign sum_s     = acc_q + {{WINWD{1'b0}}, iBit};

  ds2b_win_cnt #(.WINWD(WINWD)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .len  (dec_len_s),
    .en   (iEn),
    .run  (state_q == RUN),
    .wrap (CONT),
    .rem  (rem_s),
    .last (last_s)
  );

  // Window FSM: load restarts (and wins over a coinciding final bit), last enabled bit completes.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    oc_d    = oc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          acc_d   = {(WINWD+1){1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (load) begin
          acc_d   = {(WINWD+1){1'b0}};
          state_d = RUN;
        end else if (iEn && last_s) begin
          oc_d    = sum_s;
          done_d  = 1'b1;
          acc_d   = {(WINWD+1){1'b0}};
          state_d = CONT ? RUN : IDLE;
        end else if (iEn) begin
          acc_d = sum_s;
        end else begin
          acc_d = acc_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= {(WINWD+1){1'b0}};
      oc_q    <= {(WINWD+1){1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      oc_q    <= oc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign oC    = oc_q;
  assign oDone = done_q;
  assign oBusy = busy_q;

  // rem is only consumed through the last-bit flag.
  logic unused_s;
  assign unused_s = ^rem_s;

endmodule

// File: tb/tb_ds2b_win_uni.sv
// Scoreboard bench for ds2b_win_uni; expected counts are queued at stimulus time.
module tb_ds2b_win_uni;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] iLen;
  logic        iEn;
  logic        iBit;
  logic [16:0] oC;
  logic        oDone;
  logic        oBusy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned sb[$];

  always #5 clk = ~clk;

  ds2b_win_uni #(.INWD(8), .WINWD(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .iLen  (iLen),
    .iEn   (iEn),
    .iBit  (iBit),
    .oC    (oC),
    .oDone (oDone),
    .oBusy (oBusy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] len);
    iLen = len; load = 1'b1; iEn = 1'b1; iBit = 1'b1;
    tick();
    load = 1'b0; iEn = 1'b0; iBit = 1'b0;
  endtask

  task automatic feed(input logic en, input logic b);
    iEn = en; iBit = b;
    tick();
    iEn = 1'b0; iBit = 1'b0;
  endtask

  // Every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && oDone === 1'b1) begin
      if (sb.size() == 0) check("spurious_done", oDone, 1'b0);
      else check("oC", oC, sb.pop_front());
`ifndef DS2B_CONT_EN
      check("done_busy_excl", oBusy, 1'b0);
`endif
    end
  end

  initial begin
    int unsigned cnt, n_en, len, cyc;
    logic        en, b;
    rst = 1'b1; load = 1'b0; iLen = 16'd0; iEn = 1'b0; iBit = 1'b0;
    #1;
    check("rst_oC", oC, 0);
    check("rst_done", oDone, 0);
    check("rst_busy", oBusy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("idle_busy", oBusy, 0);

`ifdef DS2B_CONT_EN
    do_load(16'd2);
    check("cont_busy_load", oBusy, 1);
    for (int w = 0; w < 4; w++) begin
      feed(1'b1, 1'b1);
      check("cont_busy_mid", oBusy, 1);
      check("cont_done_mid", oDone, 0);
      sb.push_back(1);
      feed(1'b1, 1'b0);
      check("cont_done", oDone, 1);
      check("cont_busy_end", oBusy, 1);
    end
    do_load(16'd3);
    sb.push_back(2);
    feed(1'b1, 1'b1); feed(1'b0, 1'b1); feed(1'b1, 1'b0); feed(1'b1, 1'b1);
    check("cont_abort_busy", oBusy, 1);
`else
    // Basic window 1,0,1,1.
    do_load(16'd4);
    check("basic_busy", oBusy, 1);
    sb.push_back(3);
    feed(1'b1, 1'b1); feed(1'b1, 1'b0); feed(1'b1, 1'b1);
    check("basic_no_early_done", oDone, 0);
    feed(1'b1, 1'b1);
    check("basic_done", oDone, 1);
    check("basic_busy_fall", oBusy, 0);
    tick();
    check("basic_done_pulse", oDone, 0);
    check("basic_hold", oC, 3);

    // Enable gaps: gated bits ignored.
    do_load(16'd3);
    sb.push_back(2);
    feed(1'b1, 1'b1); feed(1'b0, 1'b1); feed(1'b1, 1'b0); feed(1'b0, 1'b1); feed(1'b1, 1'b1);
    check("gap_done", oDone, 1);
    tick();

    // Abort: first window never completes.
    do_load(16'd8);
    feed(1'b1, 1'b1); feed(1'b1, 1'b1); feed(1'b1, 1'b1);
    do_load(16'd2);
    sb.push_back(2);
    feed(1'b1, 1'b1); feed(1'b1, 1'b1);
    check("abort_done", oDone, 1);
    tick();

    // Collision: load on the final bit wins.
    do_load(16'd2);
    feed(1'b1, 1'b1);
    do_load(16'd3);
    check("coll_no_done", oDone, 0);
    check("coll_oC_hold", oC, 2);
    check("coll_busy", oBusy, 1);
    sb.push_back(1);
    feed(1'b1, 1'b0); feed(1'b1, 1'b1); feed(1'b1, 1'b0);
    tick();

    // Random windows.
    for (int w = 0; w < 6; w++) begin
      len = $urandom_range(1, 12);
      do_load(16'(len));
      cnt = 0; n_en = 0; cyc = 0;
      while (n_en < len && cyc < 1000) begin
        en = 1'($urandom_range(0, 1));
        b  = 1'($urandom_range(0, 1));
        if (en) begin
          cnt += b; n_en++;
          if (n_en == len) sb.push_back(cnt);
        end
        feed(en, b);
        cyc++;
      end
      tick();
      check("rand_idle", oBusy, 0);
    end

    // Reset mid-window drops everything immediately.
    do_load(16'd5);
    feed(1'b1, 1'b1); feed(1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_oC", oC, 0);
    check("midrst_busy", oBusy, 0);
    check("midrst_done", oDone, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    feed(1'b1, 1'b1); feed(1'b1, 1'b1); feed(1'b1, 1'b1);
    check("postrst_idle", oBusy, 0);

    // Full 2^16 window of ones.
    do_load(16'd0);
    for (int i = 0; i < 65535; i++) feed(1'b1, 1'b1);
    check("full_busy", oBusy, 1);
    sb.push_back(65536);
    feed(1'b1, 1'b1);
    check("full_done", oDone, 1);
    check("full_oC", oC, 65536);
    tick();
    check("full_idle", oBusy, 0);
`endif

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
